// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, synchronous flush and a registered read port.
module param_sync_fifo #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              active;
    logic              rd_acc;
    logic              wr_acc;

    // Status flags decode the registered occupancy.
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_CNT);
        almost_empty = (count <= AE_CNT);
        almost_full  = (count >= AF_CNT);
    end

    // Reset and flush both suppress any transfer in their cycle.
    always_comb begin
        active = rst & ~flush;
        rd_acc = active & rd_en & ~empty;
        wr_acc = active & wr_en & (~full | rd_acc);
    end

    // Storage is intentionally left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            // Flush clears state but leaves the last read word visible.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised and directed bench for param_sync_fifo against a queue-based model.
module tb_param_sync_fifo;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned AF_LEVEL = DEPTH - 1;
    localparam int unsigned AE_LEVEL = 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    param_sync_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a bounded queue plus the visible read register and sticky flags.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd_data = '0;
    bit                m_rd_valid = 1'b0;
    bit                m_ov = 1'b0;
    bit                m_un = 1'b0;

    always @(posedge clk) begin
        bit was_empty;
        bit racc;
        bit wacc;
        if (!rst) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ov       = 1'b0;
            m_un       = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rd_valid = 1'b0;
            m_ov       = 1'b0;
            m_un       = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            racc = rd_en && !was_empty;
            wacc = wr_en && ((q.size() < DEPTH) || racc);
            if (rd_en && was_empty) m_un = 1'b1;
            if (wr_en && !wacc) m_ov = 1'b1;
            if (racc) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (wacc) q.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("count",        32'(count),        32'(q.size()));
            chk("empty",        32'(empty),        32'(q.size() == 0));
            chk("full",         32'(full),         32'(q.size() == DEPTH));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE_LEVEL));
            chk("almost_full",  32'(almost_full),  32'(q.size() >= AF_LEVEL));
            chk("overflow",     32'(overflow),     32'(m_ov));
            chk("underflow",    32'(underflow),    32'(m_un));
            chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
            chk("rd_data",      32'(rd_data),      32'(m_rd_data));
        end
    end

    task automatic cyc(input bit f, input bit w, input logic [DATA_W-1:0] d, input bit r);
        flush   = f;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

        // 1: reset then fill
        cyc(0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 0);
        rst = 1'b1;
        check_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, DATA_W'(i), 0);
            chk("fill_count", 32'(count), 32'(i));
            if (i == 1) chk("fill_empty", 32'(empty), 32'd0);
            if (i == 7) chk("fill_af7", 32'(almost_full), 32'd1);
            if (i == 7) chk("fill_full7", 32'(full), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ov", 32'(overflow), 32'd0);

        // 2: overflow
        cyc(0, 1, 16'h00FF, 0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // 3: drain and latency
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 16'h0, 1);
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ov_sticky", 32'(overflow), 32'd1);
        cyc(0, 0, 16'h0, 1);
        chk("under_flag", 32'(underflow), 32'd1);
        chk("under_valid", 32'(rd_valid), 32'd0);

        // 4: simultaneous read and write at full
        cyc(1, 0, 16'h0, 0);
        for (int i = 1; i <= 8; i++) cyc(0, 1, DATA_W'(i), 0);
        cyc(0, 1, 16'hA5A5, 1);
        chk("rw_full_data", 32'(rd_data), 32'h0001);
        chk("rw_full_count", 32'(count), 32'd8);
        chk("rw_full_ov", 32'(overflow), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            cyc(0, 0, 16'h0, 1);
            chk("rw_full_seq", 32'(rd_data), (i == 9) ? 32'hA5A5 : 32'(i));
        end

        // 5: empty with simultaneous read and write
        cyc(1, 0, 16'h0, 0);
        cyc(0, 1, 16'h1234, 1);
        chk("rw_empty_valid", 32'(rd_valid), 32'd0);
        chk("rw_empty_under", 32'(underflow), 32'd1);
        chk("rw_empty_count", 32'(count), 32'd1);
        cyc(0, 0, 16'h0, 1);
        chk("rw_empty_data", 32'(rd_data), 32'h1234);

        // 6: flush and reset mid-stream
        cyc(1, 0, 16'h0, 0);
        for (int i = 1; i <= 8; i++) cyc(0, 1, DATA_W'(16 + i), 0);
        cyc(0, 1, 16'h00FF, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 1);
        chk("pre_flush_count", 32'(count), 32'd5);
        chk("pre_flush_ov", 32'(overflow), 32'd1);
        cyc(1, 1, 16'hBEEF, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ov", 32'(overflow), 32'd0);
        chk("flush_rd_hold", 32'(rd_data), 32'd19);
        cyc(0, 1, 16'h0042, 0);
        cyc(0, 1, 16'h0043, 1);
        chk("post_flush_data", 32'(rd_data), 32'h0042);
        rst = 1'b0;
        cyc(0, 0, 16'h0, 1);
        chk("rst_mid_valid", 32'(rd_valid), 32'd0);
        chk("rst_mid_data", 32'(rd_data), 32'd0);
        rst = 1'b1;

        // Randomised traffic with occasional flush and reset
        for (int n = 0; n < 4000; n++) begin
            int unsigned mode;
            mode = $urandom_range(0, 3);
            rst = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 79) == 0),
                (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
                DATA_W'($urandom),
                (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1));
        end
        rst = 1'b1;
        cyc(0, 0, 16'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO: the next generation of the team's 16-bit, 8-entry stream buffer. Width, depth and flag thresholds are configurable. Adds occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a registered read port with a data-valid strobe. Sits between a producer stage and a consumer stage in the same clock domain.

Parameters:
DATA_W, 16, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
flush  input  1  synchronous clear of contents and error flags
wr_en  input  1  write request
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_data  output  DATA_W  read data, registered
rd_valid  output  1  rd_data holds a newly read word this cycle
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write attempted while write not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst==0 at clk edge): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Storage array is not cleared. Reset overrides all other inputs.
- Priority: reset > flush > read/write.
- Flush: same effect as reset on pointers, count, rd_valid and error flags; rd_data holds its value. Any wr_en or rd_en in the flush cycle is ignored and does not set an error flag.
- Read accepted (rd_acc) = rd_en & !empty. On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the same edge, so data is visible one cycle after the request. rd_ptr increments modulo DEPTH. With no rd_acc, rd_valid <= 0 and rd_data holds.
- Write accepted (wr_acc) = wr_en & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle. On wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments modulo DEPTH.
- Empty with simultaneous rd_en and wr_en: the write is accepted, the read is not (no fall-through), and underflow sets. The word becomes readable from the next cycle.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur. Count never exceeds DEPTH and never goes below 0.
- Flags empty, full, almost_* are combinational decodes of the registered count. They are valid the cycle after the update.
- overflow <= 1 on wr_en & !wr_acc. underflow <= 1 on rd_en & empty. Both hold until reset or flush.
- Pointers are log2(DEPTH) bits and wrap naturally. Data order is strict FIFO across the wrap.

Test Plan:
1. Reset then fill: rst=0 for 2 cycles, then write 0x0001..0x0008 on consecutive cycles (DATA_W=16, DEPTH=8) -> count climbs 1..8; almost_full=1 at count 7; full=1 after the 8th write; empty=0 after the 1st write; overflow=0.
2. Overflow: with the FIFO full, wr_en=1 with 0x00FF and rd_en=0 -> count stays 8, overflow=1 and stays 1; subsequent reads return 0x0001..0x0008 with no 0x00FF.
3. Drain and latency: from full, assert rd_en for 8 cycles -> rd_valid=1 and rd_data=0x0001 in the cycle after the first request, sequence runs to 0x0008; empty=1 after the last read; a 9th rd_en sets underflow and leaves rd_valid=0.
4. Simultaneous read and write at full: full FIFO, wr_en=rd_en=1 with wr_data=0xA5A5 -> rd_data=0x0001, count stays 8, no overflow; 0xA5A5 is read out 8th after the wrap.
5. Empty with simultaneous read and write: empty FIFO, rd_en=wr_en=1 with 0x1234 -> rd_valid=0, underflow=1, count=1; the next rd_en returns 0x1234.
6. Flush and reset mid-stream: 5 entries held with overflow=1; pulse flush with wr_en=1 -> count=0, empty=1, overflow=0, and the write is dropped. Then drive rst=0 during a read -> rd_valid=0 and rd_data=0 on the next edge.
